// File: rtl/pulse_width_meter.sv
// -----------------------------------------------------------------------------
// pulse_width_meter
//
// Receive-side counterpart to the fixed-width one-shot pulse generator.
// Detects a pulse on pulse_in, counts how many clk cycles it is sampled high
// and qualifies the result against MIN_WIDTH / MAX_WIDTH. Qualified widths are
// handed downstream over a valid/ready port; pulses shorter than MIN_WIDTH
// are dropped and flagged with a one-cycle runt strobe.
//
// Optional build macro:
//   PULSE_METER_SYNC_EN  - pulse_in passes through a 2-flop synchronizer
//                          (reset to 1) before detection. Async inputs are
//                          then allowed; all detection and result timing is
//                          2 cycles later, measured widths are unchanged.
//                          Undefined: pulse_in must be clk-synchronous.
//
// Ports:
//   clk        in   1   system clock
//   reset      in   1   synchronous, active-high reset
//   pulse_in   in   1   pulse to measure
//   width_out  out  CW  measured width, held while valid
//   too_long   out  1   width > MAX_WIDTH or width counter saturated
//   valid      out  1   result available
//   ready      in   1   consumer takes the result when valid & ready
//   runt       out  1   1-cycle strobe: pulse shorter than MIN_WIDTH dropped
//   overrun    out  1   sticky: a result was lost (valid & ~ready); reset only
//   busy       out  1   FSM is not IDLE
//
// Handshake: a result transfers on every clk edge where valid & ready are
// both 1. valid, width_out and too_long are held stable while valid & ~ready.
// A new result loads when the output register is empty, or when the held
// result is being consumed in the same cycle; otherwise it is dropped and
// overrun is set.
// -----------------------------------------------------------------------------
module pulse_width_meter #(
    parameter int COUNTER_WIDTH  = 13,
    parameter int MIN_WIDTH      = 2,
    parameter int MAX_WIDTH      = 4096,
    parameter int HOLDOFF_CYCLES = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     pulse_in,
    output logic [COUNTER_WIDTH-1:0] width_out,
    output logic                     too_long,
    output logic                     valid,
    input  logic                     ready,
    output logic                     runt,
    output logic                     overrun,
    output logic                     busy
);

    localparam int CW = COUNTER_WIDTH;
    localparam int HW = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;

    localparam logic [CW-1:0] MIN_W     = CW'(MIN_WIDTH);
    localparam logic [CW-1:0] MAX_W     = CW'(MAX_WIDTH);
    localparam logic [HW-1:0] HOLD_INIT = HW'((HOLDOFF_CYCLES > 0) ? HOLDOFF_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        HOLDOFF = 2'd2
    } state_t;

    state_t          state;
    state_t          state_d;
    logic            p;
    logic            p_d;
    logic            rise;
    logic [CW-1:0]   count;
    logic [HW-1:0]   hold_cnt;
    logic            saturated;
    logic            fall_done;
    logic            new_result;
    logic            new_runt;

    // ---------------------------------------------------------------- input
`ifdef PULSE_METER_SYNC_EN
    logic [1:0] sync_q;

    // Reset to 1 so an input already high at reset release looks like a
    // continuing level, not a rising edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], pulse_in};
        end
    end

    assign p = sync_q[1];
`else
    assign p = pulse_in;
`endif

    // p_d resets high for the same reason: no partial measurement of a
    // pulse that was already in progress when reset was released.
    always_ff @(posedge clk) begin
        if (reset) begin
            p_d <= 1'b1;
        end else begin
            p_d <= p;
        end
    end

    assign rise       = p & ~p_d;
    assign saturated  = &count;
    assign fall_done  = (state == MEASURE) && !p;
    assign new_result = fall_done && (count >= MIN_W);
    assign new_runt   = fall_done && (count < MIN_W);
    assign busy       = (state != IDLE);

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (!p) begin
                    state_d = (HOLDOFF_CYCLES == 0) ? IDLE : HOLDOFF;
                end
            end
            HOLDOFF: begin
                // Rises are ignored here; a pulse still high when holdoff
                // ends never shows a rise in IDLE and so is discarded.
                if (hold_cnt == '0) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------- counters
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            hold_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rise) begin
                        count <= CW'(1);
                    end
                end
                MEASURE: begin
                    // Saturate at all-ones rather than wrap.
                    if (p && !saturated) begin
                        count <= count + CW'(1);
                    end
                    if (!p) begin
                        hold_cnt <= HOLD_INIT;
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt != '0) begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------- result output
    always_ff @(posedge clk) begin
        if (reset) begin
            width_out <= '0;
            too_long  <= 1'b0;
            valid     <= 1'b0;
            runt      <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            runt <= new_runt;

            if (new_result && (!valid || ready)) begin
                width_out <= count;
                too_long  <= (count > MAX_W) || saturated;
                valid     <= 1'b1;
            end else if (valid && ready) begin
                valid <= 1'b0;
            end

            if (new_result && valid && !ready) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pulse_width_meter.sv
// -----------------------------------------------------------------------------
// tb_pulse_width_meter
//
// Directed bench for pulse_width_meter. Two instances share clk/reset:
//   dut   - default parameters (no holdoff)
//   dut_h - HOLDOFF_CYCLES = 8
// Inputs are driven on the falling edge, outputs are sampled on the falling
// edge, so every DUT decision happens on the rising edge in between.
// With PULSE_METER_SYNC_EN defined, result timing is expected 2 cycles later.
// -----------------------------------------------------------------------------
module tb_pulse_width_meter;

    localparam int CW = 13;
`ifdef PULSE_METER_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 0;
`endif

    // ------------------------------------------------------ clock and reset
    logic clk   = 1'b0;
    logic reset = 1'b1;

    always #5 clk = ~clk;

    // ----------------------------------------------------- default instance
    logic          pulse_in = 1'b0;
    logic          ready    = 1'b1;
    logic [CW-1:0] width_out;
    logic          too_long;
    logic          valid;
    logic          runt;
    logic          overrun;
    logic          busy;

    pulse_width_meter dut (
        .clk       (clk),
        .reset     (reset),
        .pulse_in  (pulse_in),
        .width_out (width_out),
        .too_long  (too_long),
        .valid     (valid),
        .ready     (ready),
        .runt      (runt),
        .overrun   (overrun),
        .busy      (busy)
    );

    // ----------------------------------------------------- holdoff instance
    logic          pulse_h = 1'b0;
    logic          ready_h = 1'b1;
    logic [CW-1:0] width_h;
    logic          too_long_h;
    logic          valid_h;
    logic          runt_h;
    logic          overrun_h;
    logic          busy_h;

    pulse_width_meter #(.HOLDOFF_CYCLES(8)) dut_h (
        .clk       (clk),
        .reset     (reset),
        .pulse_in  (pulse_h),
        .width_out (width_h),
        .too_long  (too_long_h),
        .valid     (valid_h),
        .ready     (ready_h),
        .runt      (runt_h),
        .overrun   (overrun_h),
        .busy      (busy_h)
    );

    // ---------------------------------------------- event counting monitor
    int nv   = 0;
    int nr   = 0;
    int nv_h = 0;
    int nr_h = 0;

    always @(negedge clk) begin
        if (valid)   nv++;
        if (runt)    nr++;
        if (valid_h) nv_h++;
        if (runt_h)  nr_h++;
    end

    // ------------------------------------------------------------- checking
    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // ---------------------------------------------------------- drivers
    // Called on a falling edge: holds the pulse high for n rising edges and
    // returns on the falling edge where it is driven low again.
    task automatic pulse_a(input int n);
        pulse_in = 1'b1;
        repeat (n) @(negedge clk);
        pulse_in = 1'b0;
    endtask

    task automatic pulse_b(input int n);
        pulse_h = 1'b1;
        repeat (n) @(negedge clk);
        pulse_h = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Safety net: the directed sequence needs roughly 15k cycles.
    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    // ------------------------------------------------------------ stimulus
    initial begin
        int nv0;
        int nr0;
        int nvh0;

        // ---- reset state
        idle(3);
        chk("rst_valid",   valid,     0);
        chk("rst_width",   width_out, 0);
        chk("rst_runt",    runt,      0);
        chk("rst_overrun", overrun,   0);
        chk("rst_busy",    busy,      0);
        chk("rst_too_long", too_long, 0);
        reset = 1'b0;
        idle(4);

        // ---- 10-cycle pulse: one valid cycle, width 10
        nv0 = nv; nr0 = nr;
        pulse_a(10);
        idle(1 + LAT);
        chk("t1_valid",    valid,     1);
        chk("t1_width",    width_out, 10);
        chk("t1_too_long", too_long,  0);
        chk("t1_runt",     runt,      0);
        idle(1);
        chk("t1_valid_drop", valid, 0);
        idle(4);
        chk("t1_nvalid", nv - nv0, 1);
        chk("t1_nrunt",  nr - nr0, 0);

        // ---- 1-cycle pulse: runt strobe only
        nv0 = nv; nr0 = nr;
        pulse_a(1);
        idle(1 + LAT);
        chk("t2_runt",  runt,  1);
        chk("t2_valid", valid, 0);
        idle(1);
        chk("t2_runt_drop", runt, 0);
        idle(4);
        chk("t2_nrunt",  nr - nr0, 1);
        chk("t2_nvalid", nv - nv0, 0);

        // ---- 5000 cycles: over MAX_WIDTH
        pulse_in = 1'b1;
        idle(3);
        chk("t3_busy", busy, 1);
        idle(4997);
        pulse_in = 1'b0;
        idle(1 + LAT);
        chk("t3a_valid",    valid,     1);
        chk("t3a_width",    width_out, 5000);
        chk("t3a_too_long", too_long,  1);
        idle(4);

        // ---- 9000 cycles: counter saturates at 8191
        pulse_a(9000);
        idle(1 + LAT);
        chk("t3b_valid",    valid,     1);
        chk("t3b_width",    width_out, 8191);
        chk("t3b_too_long", too_long,  1);
        idle(4);
        chk("t3_busy_idle", busy, 0);

        // ---- back-pressure: second result dropped, overrun sticky
        ready = 1'b0;
        pulse_a(10);
        idle(1 + LAT);
        chk("t4_valid1",   valid,     1);
        chk("t4_width1",   width_out, 10);
        chk("t4_overrun0", overrun,   0);
        idle(3);
        pulse_a(20);
        idle(1 + LAT);
        chk("t4_valid2",   valid,     1);
        chk("t4_width2",   width_out, 10);
        chk("t4_overrun1", overrun,   1);
        ready = 1'b1;
        idle(1);
        chk("t4_valid_drop", valid,   0);
        chk("t4_overrun_hold", overrun, 1);
        idle(5);
        chk("t4_overrun_sticky", overrun, 1);

        // ---- reset in the middle of a 50-cycle pulse
        nv0 = nv; nr0 = nr;
        pulse_in = 1'b1;
        idle(20);
        reset = 1'b1;
        idle(3);
        chk("t5_busy_rst",    busy,    0);
        chk("t5_overrun_rst", overrun, 0);
        reset = 1'b0;
        idle(27);
        chk("t5_busy_high", busy, 0);
        pulse_in = 1'b0;
        idle(5 + LAT);
        chk("t5_nvalid", nv - nv0, 0);
        chk("t5_nrunt",  nr - nr0, 0);
        pulse_a(12);
        idle(1 + LAT);
        chk("t5_valid", valid,     1);
        chk("t5_width", width_out, 12);
        idle(4);

        // ---- holdoff: rise 4 cycles after a fall is ignored
        pulse_b(6);
        idle(1 + LAT);
        chk("t6_valid_a", valid_h, 1);
        chk("t6_width_a", width_h, 6);
        // pulse_b returned 1+LAT cycles ago; make the rise 4 cycles after the fall
        idle(3 - LAT - 1 + LAT);
        nvh0 = nv_h;
        chk("t6_busy_hold", busy_h, 1);
        pulse_b(6);
        idle(6 + LAT);
        chk("t6_ignored", nv_h - nvh0, 0);
        chk("t6_nrunt",   nr_h,        0);
        chk("t6_idle",    busy_h,      0);

        // ---- measured pulse, then a rise 12 cycles after its fall
        pulse_b(9);
        idle(1 + LAT);
        chk("t6_valid_b", valid_h, 1);
        chk("t6_width_b", width_h, 9);
        idle(11 - 1 - LAT);
        pulse_b(7);
        idle(1 + LAT);
        chk("t6_valid_c", valid_h, 1);
        chk("t6_width_c", width_h, 7);
        idle(4);
        chk("t6_overrun", overrun_h, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
